// File: rtl/target_box_overlay_pkg.sv
`default_nettype none
// ============================================================================
// target_box_overlay_pkg: shared ISP widths, FSM encoding and helpers
// Rev 1.0
// ============================================================================
package target_box_overlay_pkg;

  localparam int CW = 12;
  localparam int NW = 24;

  typedef logic [CW-1:0] coord_t;
  typedef logic [NW-1:0] count_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam coord_t COORD_MAX = '1;
  localparam count_t COUNT_MAX = '1;

  // Midpoint of two coordinates; the sum is widened by one bit so it cannot wrap.
  function automatic coord_t mid(input coord_t a, input coord_t b);
    return coord_t'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_accum.sv
`default_nettype none
// ============================================================================
// box_accum: running min/max coordinates and saturating count of mask pixels
// Rev 1.0
// ============================================================================
module box_accum
  import target_box_overlay_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   clear_i,
  input  logic   pixel_en_i,
  input  coord_t hcount_i,
  input  coord_t vcount_i,
  output coord_t xmin_o,
  output coord_t xmax_o,
  output coord_t ymin_o,
  output coord_t ymax_o,
  output count_t cnt_o
);

  coord_t xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t xmin_d, xmax_d, ymin_d, ymax_d;
  count_t cnt_q, cnt_d;

  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      xmin_d = COORD_MAX;
      xmax_d = '0;
      ymin_d = COORD_MAX;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (pixel_en_i) begin
      if (hcount_i < xmin_q) xmin_d = hcount_i;
      if (hcount_i > xmax_q) xmax_d = hcount_i;
      if (vcount_i < ymin_q) ymin_d = vcount_i;
      if (vcount_i > ymax_q) ymax_d = vcount_i;
      if (cnt_q != COUNT_MAX) cnt_d = cnt_q + count_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xmin_q <= COORD_MAX;
      xmax_q <= '0;
      ymin_q <= COORD_MAX;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
    end
  end

  assign xmin_o = xmin_q;
  assign xmax_o = xmax_q;
  assign ymin_o = ymin_q;
  assign ymax_o = ymax_q;
  assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/target_box_overlay.sv
`default_nettype none
// ============================================================================
// target_box_overlay: per-frame bounding box of a binary mask, drawn on video
// Rev 1.0
// ============================================================================
module target_box_overlay
  import target_box_overlay_pkg::*;
#(
  parameter int unsigned   DW        = 24,
  parameter int unsigned   MIN_PIX   = 16,
  parameter int unsigned   THICK     = 2,
  parameter logic [DW-1:0] BOX_COLOR = 24'hFF0000
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic [DW-1:0] i_data,
  input  logic [DW-1:0] i_binary,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [11:0]   i_hcount,
  input  logic [11:0]   i_vcount,
  output logic [DW-1:0] o_data,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [11:0]   o_xmin,
  output logic [11:0]   o_xmax,
  output logic [11:0]   o_ymin,
  output logic [11:0]   o_ymax,
  output logic [11:0]   o_cx,
  output logic [11:0]   o_cy,
  output logic [23:0]   o_pix_cnt,
  output logic          o_box_valid,
  output logic          o_frame_done
);

  localparam logic [CW:0] THICK_C = (CW+1)'(THICK);

  state_e        state_q;
  logic [DW-1:0] data_q, data_d;
  logic          hsync_q, vsync_q, de_q;
  coord_t        xmin_q, xmax_q, ymin_q, ymax_q, cx_q, cy_q;
  count_t        pix_cnt_q;
  logic          box_valid_q, frame_done_q;

  coord_t acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  count_t acc_cnt;
  logic   boundary_w, pixel_en_w;
  logic   unused_binary;

  assign unused_binary = ^i_binary[DW-1:1];

  assign boundary_w = i_vsync & ~vsync_q;
  assign pixel_en_w = (state_q == ST_ACCUM) && !boundary_w && i_de && i_binary[0];

  box_accum u_accum (
    .clk_i      (pixelclk),
    .reset_i    (reset),
    .clear_i    (state_q == ST_LATCH),
    .pixel_en_i (pixel_en_w),
    .hcount_i   (i_hcount),
    .vcount_i   (i_vcount),
    .xmin_o     (acc_xmin),
    .xmax_o     (acc_xmax),
    .ymin_o     (acc_ymin),
    .ymax_o     (acc_ymax),
    .cnt_o      (acc_cnt)
  );

  // The latched box is only rewritten in LATCH, right after the vsync edge,
  // so the overlay always draws one coherent box for the whole active frame.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      pix_cnt_q    <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_WAIT:  if (boundary_w) state_q <= ST_ACCUM;
        ST_ACCUM: if (boundary_w) state_q <= ST_LATCH;
        ST_LATCH: begin
          state_q      <= ST_ACCUM;
          xmin_q       <= acc_xmin;
          xmax_q       <= acc_xmax;
          ymin_q       <= acc_ymin;
          ymax_q       <= acc_ymax;
          cx_q         <= mid(acc_xmin, acc_xmax);
          cy_q         <= mid(acc_ymin, acc_ymax);
          pix_cnt_q    <= acc_cnt;
          box_valid_q  <= (acc_cnt >= count_t'(MIN_PIX));
          frame_done_q <= 1'b1;
        end
        default:  state_q <= ST_WAIT;
      endcase
    end
  end

  logic [CW:0] h_w, v_w, x0_w, x1_w, y0_w, y1_w;
  logic        in_box_w, on_edge_w, on_box_w;

  assign h_w  = {1'b0, i_hcount};
  assign v_w  = {1'b0, i_vcount};
  assign x0_w = {1'b0, xmin_q};
  assign x1_w = {1'b0, xmax_q};
  assign y0_w = {1'b0, ymin_q};
  assign y1_w = {1'b0, ymax_q};

  assign in_box_w  = (h_w >= x0_w) && (h_w <= x1_w) && (v_w >= y0_w) && (v_w <= y1_w);
  assign on_edge_w = (h_w < x0_w + THICK_C) || (h_w + THICK_C > x1_w) ||
                     (v_w < y0_w + THICK_C) || (v_w + THICK_C > y1_w);
  assign on_box_w  = box_valid_q && in_box_w && on_edge_w;

  always_comb begin
    data_d = '0;
    if (i_de) data_d = on_box_w ? BOX_COLOR : i_data;
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      data_q  <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      hsync_q <= i_hsync;
      vsync_q <= i_vsync;
      de_q    <= i_de;
    end
  end

  assign o_data       = data_q;
  assign o_hsync      = hsync_q;
  assign o_vsync      = vsync_q;
  assign o_de         = de_q;
  assign o_xmin       = xmin_q;
  assign o_xmax       = xmax_q;
  assign o_ymin       = ymin_q;
  assign o_ymax       = ymax_q;
  assign o_cx         = cx_q;
  assign o_cy         = cy_q;
  assign o_pix_cnt    = pix_cnt_q;
  assign o_box_valid  = box_valid_q;
  assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire
